// File: rtl/mac_operand_serializer_pkg.sv
// ---------------------------------------------------------------------------
// mac_operand_serializer_pkg
// Shared definitions for the MAC operand serializer:
//   - default operand widths and FIFO depth
//   - width of the wrapping operation counters
//   - 3-bit FSM state encoding
// ---------------------------------------------------------------------------
package mac_operand_serializer_pkg;

    localparam int DEF_MULTIPLICAND_WIDTH = 4;
    localparam int DEF_MULTIPLIER_WIDTH   = 4;
    localparam int DEF_FIFO_DEPTH         = 2;
    localparam int OPS_COUNT_WIDTH        = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_START     = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mac_operand_serializer_operand_fifo.sv
// ---------------------------------------------------------------------------
// operand_fifo
// Show-ahead synchronous FIFO holding {clear, multiplicand, multiplier}
// operand records. Head entry is visible on pop_data whenever empty=0.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (flushes pointers)
//   push, push_data write request (ignored while full) and data
//   pop             read request (ignored while empty)
//   pop_data        current head entry
//   count           number of stored entries
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module operand_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_serializer.sv
// ---------------------------------------------------------------------------
// mac_operand_serializer
// Buffers parallel (multiplicand, multiplier) pairs and replays each one to a
// bit-serial MAC: optional one-cycle accumulator clear, start pulse, held
// multiplicand, multiplier LSB-first, then wait for the MAC's done.
// Optional build macro: MAC_ZERO_SKIP_EN -- discards zero-multiplier pairs
// (clear-only pairs still issue the clear) and adds the skipped_ops port.
// Ports:
//   clk, rst                           clock, asynchronous active-low reset
//   in_valid/in_ready                  operand pair handshake
//   in_multiplicand/in_multiplier      operand pair
//   in_clear                           clear accumulator before this pair
//   mac_start, mac_clear_acc           one-cycle MAC control pulses
//   mac_multiplicand, mac_serial_bit   MAC operands
//   mac_done                           MAC completion
//   skipped_ops                        discarded pair count (macro only)
//   busy                               FSM active or FIFO non-empty
//   ops_issued                         wrapping count of started operations
// ---------------------------------------------------------------------------
module mac_operand_serializer
    import mac_operand_serializer_pkg::*;
#(
    parameter int MULTIPLICAND_WIDTH = DEF_MULTIPLICAND_WIDTH,
    parameter int MULTIPLIER_WIDTH   = DEF_MULTIPLIER_WIDTH,
    parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MULTIPLICAND_WIDTH-1:0] in_multiplicand,
    input  logic [MULTIPLIER_WIDTH-1:0]   in_multiplier,
    input  logic                          in_clear,
    output logic                          mac_start,
    output logic                          mac_clear_acc,
    output logic [MULTIPLICAND_WIDTH-1:0] mac_multiplicand,
    output logic                          mac_serial_bit,
    input  logic                          mac_done,
`ifdef MAC_ZERO_SKIP_EN
    output logic [OPS_COUNT_WIDTH-1:0]    skipped_ops,
`endif
    output logic                          busy,
    output logic [OPS_COUNT_WIDTH-1:0]    ops_issued
);

    localparam int FW = 1 + MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
    localparam int BW = $clog2(MULTIPLIER_WIDTH + 1);

    // FIFO interface
    logic                          fifo_pop;
    logic [FW-1:0]                 fifo_head;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          head_clear;
    logic [MULTIPLICAND_WIDTH-1:0] head_mcand;
    logic [MULTIPLIER_WIDTH-1:0]   head_mplier;

    // Sequencer state
    state_t                        state_reg, state_next;
    logic [MULTIPLICAND_WIDTH-1:0] mcand_reg, mcand_next;
    logic [MULTIPLIER_WIDTH-1:0]   shift_reg, shift_next;
    logic [BW-1:0]                 bit_cnt_reg, bit_cnt_next;
    logic [OPS_COUNT_WIDTH-1:0]    ops_reg, ops_next;
`ifdef MAC_ZERO_SKIP_EN
    logic                          clear_only_reg, clear_only_next;
    logic [OPS_COUNT_WIDTH-1:0]    skipped_reg, skipped_next;
`endif

    assign in_ready = !fifo_full;

    operand_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_clear, in_multiplicand, in_multiplier}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_clear  = fifo_head[FW-1];
    assign head_mcand  = fifo_head[MULTIPLIER_WIDTH +: MULTIPLICAND_WIDTH];
    assign head_mplier = fifo_head[MULTIPLIER_WIDTH-1:0];

    always_comb begin
        state_next     = state_reg;
        mcand_next     = mcand_reg;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        ops_next       = ops_reg;
`ifdef MAC_ZERO_SKIP_EN
        clear_only_next = clear_only_reg;
        skipped_next    = skipped_reg;
`endif
        fifo_pop       = 1'b0;
        mac_start      = 1'b0;
        mac_clear_acc  = 1'b0;
        mac_serial_bit = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
`ifdef MAC_ZERO_SKIP_EN
                    // Zero multiplier: nothing to serialize. The multiplicand
                    // output is left untouched so it keeps its last value.
                    if (head_mplier == '0) begin
                        skipped_next = skipped_reg + 1'b1;
                        if (head_clear) begin
                            clear_only_next = 1'b1;
                            state_next      = ST_CLEAR;
                        end
                    end else
`endif
                    begin
                        mcand_next = head_mcand;
                        shift_next = head_mplier;
`ifdef MAC_ZERO_SKIP_EN
                        clear_only_next = 1'b0;
`endif
                        state_next = head_clear ? ST_CLEAR : ST_START;
                    end
                end
            end

            ST_CLEAR: begin
                mac_clear_acc = 1'b1;
`ifdef MAC_ZERO_SKIP_EN
                state_next = clear_only_reg ? ST_IDLE : ST_START;
`else
                state_next = ST_START;
`endif
            end

            ST_START: begin
                mac_start      = 1'b1;
                mac_serial_bit = shift_reg[0];
                shift_next     = shift_reg >> 1;
                ops_next       = ops_reg + 1'b1;
                bit_cnt_next   = BW'(1);
                state_next     = ST_SHIFT;
            end

            ST_SHIFT: begin
                // bit_cnt_reg is the index of the bit currently on the wire.
                mac_serial_bit = shift_reg[0];
                shift_next     = shift_reg >> 1;
                if (bit_cnt_reg == BW'(MULTIPLIER_WIDTH - 1)) begin
                    state_next = ST_WAIT_DONE;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (mac_done) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            mcand_reg   <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            ops_reg     <= '0;
`ifdef MAC_ZERO_SKIP_EN
            clear_only_reg <= 1'b0;
            skipped_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            ops_reg     <= ops_next;
`ifdef MAC_ZERO_SKIP_EN
            clear_only_reg <= clear_only_next;
            skipped_reg    <= skipped_next;
`endif
        end
    end

    assign mac_multiplicand = mcand_reg;
    assign ops_issued       = ops_reg;
    assign busy             = (state_reg != ST_IDLE) || (fifo_count != '0);
`ifdef MAC_ZERO_SKIP_EN
    assign skipped_ops      = skipped_reg;
`endif

endmodule

// File: tb/tb_mac_operand_serializer.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_serializer
// Drives operand pairs (directed and $urandom) into the serializer and models
// the downstream MAC: reconstructs each serial operation from the pins,
// accumulates multiplicand*multiplier, and compares against a reference built
// from the queue of accepted pairs.
// Build macro honoured: MAC_ZERO_SKIP_EN.
// ---------------------------------------------------------------------------
module tb_mac_operand_serializer;
    import mac_operand_serializer_pkg::*;

    localparam int MW = DEF_MULTIPLICAND_WIDTH;
    localparam int NW = DEF_MULTIPLIER_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in_multiplicand = '0;
    logic [NW-1:0] in_multiplier = '0;
    logic          in_clear = 1'b0;
    logic          mac_start;
    logic          mac_clear_acc;
    logic [MW-1:0] mac_multiplicand;
    logic          mac_serial_bit;
    logic          mac_done = 1'b0;
    logic          busy;
    logic [15:0]   ops_issued;
`ifdef MAC_ZERO_SKIP_EN
    logic [15:0]   skipped_ops;
`endif

    always #5 clk = ~clk;

    mac_operand_serializer dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .in_clear         (in_clear),
        .mac_start        (mac_start),
        .mac_clear_acc    (mac_clear_acc),
        .mac_multiplicand (mac_multiplicand),
        .mac_serial_bit   (mac_serial_bit),
        .mac_done         (mac_done),
`ifdef MAC_ZERO_SKIP_EN
        .skipped_ops      (skipped_ops),
`endif
        .busy             (busy),
        .ops_issued       (ops_issued)
    );

    typedef struct {
        int a;
        int b;
        int c;
    } pair_t;

    pair_t q[$];
    int    checks = 0;
    int    failures = 0;
    int    expected_ops = 0;
    int    expected_skipped = 0;
    int    acc_ref = 0;
    int    acc_pins = 0;
    int    start_seen = 0;
    bit    stall = 0;

    // MAC model state
    int          phase = 0;
    int          bitn = 0;
    int          wcnt = 0;
    logic [31:0] bits = '0;
    logic [31:0] mc_hold = '0;
    pair_t       head;
    bit          prev_clear = 0;
    bit          done_fired = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Zero-multiplier pairs never reach the MAC when skipping is enabled;
    // apply their clear to the reference accumulator and drop them.
    function automatic void drain_skipped();
`ifdef MAC_ZERO_SKIP_EN
        while (q.size() > 0 && q[0].b == 0) begin
            if (q[0].c != 0) acc_ref = 0;
            void'(q.pop_front());
        end
`endif
    endfunction

    // Downstream MAC model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            phase      = 0;
            mac_done   = 1'b0;
            prev_clear = 0;
            done_fired = 0;
        end else begin
            if (mac_start || mac_clear_acc)
                check("start_clear_exclusive", 32'(mac_start & mac_clear_acc), 32'd0);
            if (mac_clear_acc) acc_pins = 0;
            case (phase)
                0: begin
                    if (mac_start) begin
                        start_seen++;
                        drain_skipped();
                        if (q.size() == 0) begin
                            check("start_without_pair", 32'd1, 32'd0);
                        end else begin
                            head = q.pop_front();
                            check("clear_before_start", 32'(prev_clear), 32'(head.c));
                            check("multiplicand", 32'(mac_multiplicand), 32'(head.a));
                            bits    = 32'(mac_serial_bit);
                            bitn    = 1;
                            mc_hold = 32'(mac_multiplicand);
                            phase   = 1;
                            // spurious done outside WAIT_DONE must be ignored
                            mac_done = ($urandom_range(0, 3) == 0);
                        end
                    end else begin
`ifndef MAC_ZERO_SKIP_EN
                        if (prev_clear) check("start_after_clear", 32'(mac_start), 32'd1);
`endif
                    end
                end
                1: begin
                    check("no_pulse_in_shift", 32'({mac_start, mac_clear_acc}), 32'd0);
                    check("multiplicand_held", 32'(mac_multiplicand), mc_hold);
                    bits = bits | (32'(mac_serial_bit) << bitn);
                    bitn++;
                    if (bitn == NW) begin
                        mac_done = 1'b0;
                        check("multiplier_bits", bits, 32'(head.b));
                        acc_ref  = ((head.c != 0) ? 0 : acc_ref) + head.a * head.b;
                        acc_pins = acc_pins + int'(mc_hold) * int'(bits);
                        check("accumulator", 32'(acc_pins), 32'(acc_ref));
                        phase      = 2;
                        wcnt       = $urandom_range(0, 3);
                        done_fired = 0;
                    end else begin
                        mac_done = ($urandom_range(0, 3) == 0);
                    end
                end
                default: begin
                    check("wait_serial_zero", 32'({mac_serial_bit, mac_start}), 32'd0);
                    check("wait_multiplicand_held", 32'(mac_multiplicand), mc_hold);
                    if (done_fired) begin
                        mac_done = 1'b0;
                        phase    = 0;
                    end else if (!stall) begin
                        if (wcnt == 0) begin
                            mac_done   = 1'b1;
                            done_fired = 1;
                        end else begin
                            wcnt--;
                        end
                    end
                end
            endcase
            prev_clear = mac_clear_acc;
        end
    end

    task automatic push_pair(input int a, input int b, input int c, output int waited);
        waited = 0;
        @(negedge clk);
        in_valid        = 1'b1;
        in_multiplicand = MW'(a);
        in_multiplier   = NW'(b);
        in_clear        = c[0];
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("push_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            q.push_back('{a: a, b: b, c: c});
`ifdef MAC_ZERO_SKIP_EN
            if (b == 0) expected_skipped++;
            else expected_ops++;
`else
            expected_ops++;
`endif
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || phase != 0 || mac_done) && n < 3000);
        if (n >= 3000) check("idle_timeout", 32'd0, 32'd1);
        drain_skipped();
        check({tag, "_ops_issued"}, 32'(ops_issued), 32'(expected_ops));
        check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
`ifdef MAC_ZERO_SKIP_EN
        check({tag, "_skipped_ops"}, 32'(skipped_ops), 32'(expected_skipped));
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int w;
        int w2;
        int w3;
        int ops_before;
        int starts_before;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ops", 32'(ops_issued), 32'd0);
        check("reset_pulses", 32'({mac_start, mac_clear_acc, mac_serial_bit}), 32'd0);
        check("reset_multiplicand", 32'(mac_multiplicand), 32'd0);
        rst = 1'b1;

        // Single pair with clear
        push_pair(2, 6, 1, w);
        wait_idle("single");
        check("single_acc", 32'(acc_pins), 32'h0C);

        // Back-to-back pairs
        push_pair(2, 6, 1, w);
        push_pair(3, 4, 0, w2);
        check("b2b_ready_first", 32'(w), 32'd0);
        check("b2b_ready_second", 32'(w2), 32'd0);
        wait_idle("b2b");
        check("b2b_acc", 32'(acc_pins), 32'h18);

        // Fill the FIFO while the MAC holds off done
        stall = 1;
        push_pair(1, 3, 1, w);
        push_pair(5, 7, 0, w2);
        push_pair(9, 2, 0, w3);
        check("fill_third_no_wait", 32'(w3), 32'd0);
        repeat (2) @(negedge clk);
        check("fill_in_ready_low", 32'(in_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        stall = 0;
        wait_idle("fill");
        check("fill_acc", 32'(acc_pins), 32'(3 + 35 + 18));

        // All-ones operands
        push_pair(15, 15, 1, w);
        wait_idle("ones");
        check("ones_acc", 32'(acc_pins), 32'hE1);

        // Zero multiplier
        ops_before = expected_ops;
        push_pair(5, 0, 0, w);
        wait_idle("zero");
`ifdef MAC_ZERO_SKIP_EN
        check("zero_skip_ops_unchanged", 32'(ops_issued), 32'(ops_before));
`else
        check("zero_serialized_ops", 32'(ops_issued), 32'(ops_before + 1));
`endif
        check("zero_acc_unchanged", 32'(acc_pins), 32'hE1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            push_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("random");

        // Reset in the middle of a shift with a pair still queued
        push_pair(7, 11, 0, w);
        push_pair(3, 5, 0, w);
        begin
            int n = 0;
            while (!(phase == 1 && bitn == 2) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("midshift_timeout", 32'd0, 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        q.delete();
        expected_ops = 0;
        expected_skipped = 0;
        check("abort_pulses", 32'({mac_start, mac_clear_acc, mac_serial_bit}), 32'd0);
        check("abort_multiplicand", 32'(mac_multiplicand), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_ops", 32'(ops_issued), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        starts_before = start_seen;
        repeat (12) @(negedge clk);
        check("abort_no_restart", 32'(start_seen), 32'(starts_before));
        check("abort_idle_busy", 32'(busy), 32'd0);
`ifdef MAC_ZERO_SKIP_EN
        check("abort_skipped", 32'(skipped_ops), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
